// File: rtl/float_pkg.sv
// Shared widths, limits and FSM encoding for the sample normalizer.
package float_pkg;

  localparam int DATA_W = 12;
  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;
  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/abs_sat.sv
// Combinational two's-complement magnitude; the most negative code saturates to the
// largest positive magnitude and raises sat.
module abs_sat
  import float_pkg::*;
#(
  parameter int DATA_W = float_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] mag,
  output logic              sat
);

  always_comb begin
    sat = (in_data == {1'b1, {(DATA_W-1){1'b0}}});
    if (sat)
      mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (in_data[DATA_W-1])
      mag = -in_data;
    else
      mag = in_data;
  end

endmodule

// File: rtl/float_normalize.sv
// Sequential normalizer: accepts one sample, shifts its magnitude left until the
// leading one reaches the top magnitude bit (or the exponent bottoms out), then holds the result.
module float_normalize
  import float_pkg::*;
#(
  parameter int DATA_W = float_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [SIG_W-1:0]     significand,
  output logic                 fifth_bit,
  output logic                 sat
);

  // Top bit of the magnitude is always zero after saturation, so the leading one
  // is aligned to bit DATA_W-2.
  localparam int LEAD = DATA_W - 2;

  state_e              state_q;
  logic [DATA_W-1:0]   mag_q;
  logic [EXP_W-1:0]    exp_cnt_q;
  logic                out_valid_q;
  logic                sign_q;
  logic [EXP_W-1:0]    exponent_q;
  logic [SIG_W-1:0]    significand_q;
  logic                fifth_bit_q;
  logic                sat_q;

  logic [DATA_W-1:0]   abs_mag;
  logic                abs_sat_flag;

  abs_sat #(.DATA_W(DATA_W)) u_abs_sat (
    .in_data (in_data),
    .mag     (abs_mag),
    .sat     (abs_sat_flag)
  );

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign sign        = sign_q;
  assign exponent    = exponent_q;
  assign significand = significand_q;
  assign fifth_bit   = fifth_bit_q;
  assign sat         = sat_q;

  // NOTE: every state register uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mag_q         <= '0;
      exp_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      sign_q        <= 1'b0;
      exponent_q    <= '0;
      significand_q <= '0;
      fifth_bit_q   <= 1'b0;
      sat_q         <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q    <= in_data[DATA_W-1];
            mag_q     <= abs_mag;
            sat_q     <= abs_sat_flag;
            exp_cnt_q <= EXP_MAX;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (mag_q[LEAD] || (exp_cnt_q == '0)) begin
            exponent_q    <= exp_cnt_q;
            significand_q <= mag_q[LEAD -: SIG_W];
            fifth_bit_q   <= mag_q[LEAD-SIG_W];
            out_valid_q   <= 1'b1;
            state_q       <= DONE;
          end else begin
            mag_q     <= mag_q << 1;
            exp_cnt_q <= exp_cnt_q - 1'b1;
          end
        end
        DONE: begin
          // Result fields are left untouched on release so downstream may still read them.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_normalize.sv
// Self-checking bench for float_normalize: vector table plus reset, back-pressure and
// streaming corner cases, with expected results queued at transfer time.
module tb_float_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [2:0]  exponent;
  logic [3:0]  significand;
  logic        fifth_bit;
  logic        sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] data;
    logic        s;
    logic [2:0]  e;
    logic [3:0]  sig;
    logic        f;
    logic        st;
    int          lat;
  } vec_t;

  vec_t sb[$];
  vec_t table_v[12];

  float_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sign        (sign),
    .exponent    (exponent),
    .significand (significand),
    .fifth_bit   (fifth_bit),
    .sat         (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference built from the leading-zero count of the 12-bit magnitude.
  function automatic vec_t model(input logic [11:0] d);
    vec_t r;
    logic [11:0] m;
    int p;
    int lz;
    r.data = d;
    r.s    = d[11];
    r.st   = (d == 12'h800);
    m      = r.st ? 12'h7FF : (d[11] ? 12'(-d) : d);
    p      = -1;
    for (int i = 0; i < 12; i++) if (m[i]) p = i;
    lz = 11 - p;
    if (lz <= 8) begin
      r.e   = 3'(8 - lz);
      r.sig = 4'(m >> (p - 3));
      r.f   = (p >= 4) ? m[p-4] : 1'b0;
    end else begin
      r.e   = 3'd0;
      r.sig = m[3:0];
      r.f   = 1'b0;
    end
    r.lat = (lz > 8) ? 8 : lz;
    return r;
  endfunction

  // Drives one sample, checks latency and result, optionally back-pressures for hold cycles.
  task automatic send(input vec_t v, input int hold);
    vec_t x;
    int lat;
    logic [2:0] e_snap;
    logic [3:0] s_snap;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1'b1);
    out_ready = (hold == 0);
    in_data   = v.data;
    in_valid  = 1'b1;
    @(posedge clk);
    sb.push_back(v);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_busy", in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    x = sb.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout data=%0h: no out_valid after %0d cycles", x.data, lat);
      return;
    end
    check($sformatf("lat_%0h", x.data), lat, x.lat);
    check($sformatf("sign_%0h", x.data), sign, x.s);
    check($sformatf("exp_%0h", x.data), exponent, x.e);
    check($sformatf("sig_%0h", x.data), significand, x.sig);
    check($sformatf("fifth_%0h", x.data), fifth_bit, x.f);
    check($sformatf("sat_%0h", x.data), sat, x.st);
    e_snap = exponent;
    s_snap = significand;
    if (hold > 0) begin
      in_valid = 1'b1;
      in_data  = 12'h123;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_exp", exponent, x.e);
        check("hold_sig", significand, x.sig);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check("release_valid", out_valid, 1'b0);
    check("release_in_ready", in_ready, 1'b1);
    check("release_keep_exp", exponent, e_snap);
    check("release_keep_sig", significand, s_snap);
  endtask

  initial begin
    int transfers;
    int results;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    table_v[0]  = '{12'h400, 1'b0, 3'd7, 4'b1000, 1'b0, 1'b0, 1};
    table_v[1]  = '{12'hFFF, 1'b1, 3'd0, 4'b0001, 1'b0, 1'b0, 8};
    table_v[2]  = '{12'h800, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b1, 1};
    table_v[3]  = '{12'd46,  1'b0, 3'd2, 4'b1011, 1'b1, 1'b0, 6};
    table_v[4]  = '{12'd300, 1'b0, 3'd5, 4'b1001, 1'b0, 1'b0, 3};
    table_v[5]  = '{12'd0,   1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 8};
    table_v[6]  = '{12'h7FF, 1'b0, 3'd7, 4'b1111, 1'b1, 1'b0, 1};
    table_v[7]  = '{12'd15,  1'b0, 3'd0, 4'b1111, 1'b0, 1'b0, 8};
    table_v[8]  = '{12'd16,  1'b0, 3'd1, 4'b1000, 1'b0, 1'b0, 7};
    table_v[9]  = '{12'hFD2, 1'b1, 3'd2, 4'b1011, 1'b1, 1'b0, 6};
    table_v[10] = '{12'h801, 1'b1, 3'd7, 4'b1111, 1'b1, 1'b0, 1};
    table_v[11] = '{12'd100, 1'b0, 3'd3, 4'b1100, 1'b1, 1'b0, 5};

    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_fields", {sign, exponent, significand, fifth_bit, sat}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (table_v[i]) send(table_v[i], 0);

    // Back-pressure: result must hold while out_ready is low.
    send(table_v[3], 3);

    // Reset in the middle of SHIFT drops the sample immediately.
    @(negedge clk);
    in_data  = 12'd5;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_exp", exponent, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(table_v[4], 0);

    for (int i = 0; i < 20; i++) send(model(12'($urandom_range(0, 4095))), 0);

    // Streaming: in_valid held high gives one transfer per consumed result.
    @(negedge clk);
    in_data   = 12'h400;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    transfers = 0;
    results   = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_valid && in_ready) transfers++;
      if (out_valid && out_ready) results++;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stream_transfers", transfers, 10);
    check("stream_results", results, 10);
    check("stream_idle", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_normalize.md
FLOAT_NORMALIZE -- requirements
Module: float_normalize

Interface
REQ-001: Parameter DATA_W, default 12, width of the two's-complement input sample.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  in_data is presented for transfer.
REQ-005: in_data  input  12  two's-complement sample to be normalized.
REQ-006: in_ready  output  1  block accepts a sample; high only in IDLE.
REQ-007: out_valid  output  1  sign/exponent/significand/fifth_bit hold a result.
REQ-008: out_ready  input  1  downstream rounding stage consumes the result.
REQ-009: sign  output  1  sign of the accepted sample.
REQ-010: exponent  output  3  unrounded exponent, 0..7.
REQ-011: significand  output  4  four bits starting at the leading one (unrounded).
REQ-012: fifth_bit  output  1  bit directly below the significand, used by rounding.
REQ-013: sat  output  1  accepted sample was -2048 and was saturated.

Function
REQ-014: FSM states are IDLE, SHIFT and DONE; reset state is IDLE.
REQ-015: A transfer occurs on a rising edge with in_valid=1 and in_ready=1. On that edge: sign<=in_data[11], mag<=|in_data|, exp_cnt<=7, state<=SHIFT.
REQ-016: Magnitude of 12'h800 (-2048) saturates to 12'h7FF, with sat<=1. sat<=0 for all other samples.
REQ-017: In SHIFT, if mag[10]=1 or exp_cnt=0, the next edge loads exponent<=exp_cnt, significand<=mag[10:7], fifth_bit<=mag[6] and out_valid<=1, and the FSM enters DONE.
REQ-018: Otherwise, in SHIFT the next edge sets mag<=mag<<1 (zero fill) and exp_cnt<=exp_cnt-1.
REQ-019: Latency from the transfer edge to out_valid high is 1+N cycles, where N is the number of shifts (0..7). Worst case is 8 cycles, for |x|<16.
REQ-020: The result equals the leading-zero encoding of the 12-bit magnitude: lz<=8 gives exponent=8-lz, and lz>=8 gives exponent=0 with significand=mag[3:0] and fifth_bit=0.
REQ-021: In DONE, all outputs hold stable while out_ready=0.
REQ-022: On the first edge in DONE with out_ready=1, out_valid<=0 and state<=IDLE. The result outputs keep their last values.
REQ-023: in_ready=0 in SHIFT and DONE, so samples presented then are not consumed. There is no overlap of consecutive samples.
REQ-024: in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

Reset
REQ-025: rst_n=0 immediately forces state=IDLE and clears out_valid, sign, exponent, significand, fifth_bit, sat, mag and exp_cnt to 0, regardless of clk.
REQ-026: Reset asserted in SHIFT or DONE discards the in-flight sample; no partial result is presented.
REQ-027: in_ready=1 during and after reset, because it is decoded from state==IDLE.
REQ-028: The first transfer may occur on the first rising edge after rst_n deasserts.

Structure
REQ-029: Shared package float_pkg holds DATA_W=12, EXP_W=3, SIG_W=4, EXP_MAX=7 and the state encoding.
REQ-030: One combinational sub-module, abs_sat, produces the 12-bit magnitude and the sat flag from in_data. The FSM, shifter and counter reside in float_normalize.

Verification
REQ-031: in_data=12'h400 (1024) -> sign=0, exponent=7, significand=1000, fifth_bit=0, sat=0; out_valid 1 cycle after the transfer.
REQ-032: in_data=12'hFFF (-1) -> sign=1, exponent=0, significand=0001, fifth_bit=0; out_valid 8 cycles after the transfer.
REQ-033: in_data=12'h800 (-2048) -> sign=1, sat=1, exponent=7, significand=1111, fifth_bit=1.
REQ-034: in_data=12'd46, with out_ready held 0 for 3 cycles -> exponent=2, significand=1011, fifth_bit=1, latency 6 cycles. Outputs must stay stable and in_ready must stay 0 until out_ready=1.
REQ-035: rst_n pulsed low mid-SHIFT during a sample of 12'd5 -> out_valid=0 and in_ready=1 immediately. A following sample of 12'd300 then yields exponent=5, significand=1001, fifth_bit=0.
REQ-036: in_valid held high continuously with out_ready=1 -> exactly one transfer per result. No sample is accepted while in SHIFT or DONE.
